// File: rtl/fft8_frame_ctrl.sv
// Frame controller for an 8-point FFT/IFFT butterfly core: gathers 8 samples,
// runs the core with a completion filter and timeout, then streams results out.
module fft8_frame_ctrl #(
  parameter int W         = 16,
  parameter int CAP_DELAY = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_mode_in,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [W-1:0]    i_in_re,
  input  logic [W-1:0]    i_in_im,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [W-1:0]    o_out_re,
  output logic [W-1:0]    o_out_im,
  output logic            o_out_last,
  output logic            o_core_en,
  output logic            o_core_mode,
  output logic [16*W-1:0] o_core_x,
  input  logic            i_core_done,
  input  logic [16*W-1:0] i_core_y,
  output logic            o_busy,
  output logic            o_err,
  output logic [7:0]      o_frame_cnt
);

  // state | meaning
  // LOAD  | accepting input samples into in_buf
  // RUN   | core enabled, waiting for a filtered core_done or timeout
  // DRAIN | streaming out_buf to the output handshake
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DW = $clog2(CAP_DELAY + 1);
  localparam int RW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DONE_TC = DW'(CAP_DELAY);
  localparam logic [RW-1:0] RUN_TC  = RW'(TIMEOUT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_wr_idx;
  logic [2:0]    r_rd_idx;
  logic [2:0]    w_wr_nxt;
  logic [2:0]    w_rd_nxt;
  logic [DW-1:0] r_done_cnt;
  logic [DW-1:0] w_done_nxt;
  logic [DW-1:0] w_done_inc;
  logic [RW-1:0] r_run_cnt;
  logic [RW-1:0] w_run_nxt;
  logic [RW-1:0] w_run_inc;
  logic          w_in_acc;
  logic          w_out_acc;
  logic          w_capture;
  logic          w_timeout;

  logic [W-1:0]  r_in_re  [8];
  logic [W-1:0]  r_in_im  [8];
  logic [W-1:0]  r_out_re [8];
  logic [W-1:0]  r_out_im [8];

  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_core_en;
  logic          r_core_mode;
  logic          r_busy;
  logic          r_err;
  logic [7:0]    r_frame_cnt;

  logic [W-1:0]  w_sel_re;
  logic [W-1:0]  w_sel_im;

  // Rounded divide-by-8 in W+1 bits so v+4 cannot overflow.
  function automatic logic [W-1:0] ifft_scale(input logic [W-1:0] v);
    logic signed [W:0] ext;
    ext = $signed({v[W-1], v}) + $signed((W+1)'(4));
    ext = ext >>> 3;
    return ext[W-1:0];
  endfunction

  assign w_done_inc = r_done_cnt + DW'(1);
  assign w_run_inc  = r_run_cnt + RW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr_idx;
    w_rd_nxt    = r_rd_idx;
    w_done_nxt  = '0;
    w_run_nxt   = '0;
    w_in_acc    = 1'b0;
    w_out_acc   = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      LOAD: begin
        if (i_in_valid) begin
          w_in_acc = 1'b1;
          w_wr_nxt = r_wr_idx + 3'd1;
          if (r_wr_idx == 3'd7) w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_run_nxt = w_run_inc;
        if (i_core_done) w_done_nxt = w_done_inc;
        // A capture on the last allowed cycle wins over the timeout.
        if (i_core_done && (w_done_inc == DONE_TC)) begin
          w_capture   = 1'b1;
          w_state_nxt = DRAIN;
        end else if (w_run_inc == RUN_TC) begin
          w_timeout   = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      DRAIN: begin
        if (i_out_ready) begin
          w_out_acc = 1'b1;
          w_rd_nxt  = r_rd_idx + 3'd1;
          if (r_rd_idx == 3'd7) w_state_nxt = LOAD;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= LOAD;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_done_cnt  <= '0;
      r_run_cnt   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_core_en   <= 1'b0;
      r_busy      <= 1'b0;
      r_core_mode <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_idx    <= w_wr_nxt;
      r_rd_idx    <= w_rd_nxt;
      r_done_cnt  <= w_done_nxt;
      r_run_cnt   <= w_run_nxt;
      r_in_ready  <= (w_state_nxt == LOAD);
      r_out_valid <= (w_state_nxt == DRAIN);
      r_core_en   <= (w_state_nxt == RUN);
      r_busy      <= (w_state_nxt != LOAD) || (w_wr_nxt != 3'd0);
      if (w_in_acc && (r_wr_idx == 3'd0)) r_core_mode <= i_mode_in;
      if (w_timeout) r_err <= 1'b1;
      if (w_out_acc && (r_rd_idx == 3'd7)) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        r_in_re[k]  <= '0;
        r_in_im[k]  <= '0;
        r_out_re[k] <= '0;
        r_out_im[k] <= '0;
      end
    end else begin
      if (w_in_acc) begin
        r_in_re[r_wr_idx] <= i_in_re;
        r_in_im[r_wr_idx] <= i_in_im;
      end
      if (w_capture) begin
        for (int k = 0; k < 8; k++) begin
          r_out_re[k] <= i_core_y[2*k*W +: W];
          r_out_im[k] <= i_core_y[2*k*W+W +: W];
        end
      end
    end
  end

  always_comb begin
    o_core_x = '0;
    for (int k = 0; k < 8; k++) begin
      o_core_x[2*k*W +: W]   = r_in_re[k];
      o_core_x[2*k*W+W +: W] = r_in_im[k];
    end
  end

  // Output data is a mux of held registers, so it is stable under backpressure.
  assign w_sel_re = r_out_re[r_rd_idx];
  assign w_sel_im = r_out_im[r_rd_idx];
  assign o_out_re = r_core_mode ? ifft_scale(w_sel_re) : w_sel_re;
  assign o_out_im = r_core_mode ? ifft_scale(w_sel_im) : w_sel_im;

  assign o_out_last  = r_out_valid && (r_rd_idx == 3'd7);
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_core_en   = r_core_en;
  assign o_core_mode = r_core_mode;
  assign o_busy      = r_busy;
  assign o_err       = r_err;
  assign o_frame_cnt = r_frame_cnt;

endmodule
